// File: rtl/instr_sequencer.sv
// Instruction fetch/issue sequencer: a small program buffer, walked by a PC,
// issues one registered 32-bit word per cycle onto the core's Instr bus.
module instr_sequencer #(
    parameter int          AW      = 4,
    parameter int          DEPTH   = 16,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    input  logic          start,
    input  logic          step_mode,
    input  logic          step,
    input  logic          abort,
    output logic [31:0]   instr,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic [15:0]   instr_count
);

    typedef enum logic [1:0] {IDLE, RUN, STEP_WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   instr_q, instr_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          done_q, done_d;
    logic [15:0]   count_q, count_d;
    logic          launch_q, launch_d;
    logic          fetch_en;
    logic [31:0]   fetch_w;
    logic          busy_w;

    logic [31:0]   mem [DEPTH];

    assign busy_w  = (state_q == RUN) || (state_q == STEP_WAIT);
    assign fetch_w = mem[pc_q];

    // NOTE: the program buffer has no reset; its contents must survive rst.
    always_ff @(posedge clk) begin
        if (prog_we && !busy_w)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            pc_q     <= '0;
            done_q   <= 1'b0;
            count_q  <= '0;
            launch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            done_q   <= done_d;
            count_q  <= count_d;
            launch_q <= launch_d;
        end
    end

    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        instr_d  = '0;
        valid_d  = 1'b0;
        pc_d     = pc_q;
        done_d   = done_q;
        count_d  = count_q;
        launch_d = 1'b0;
        fetch_en = 1'b0;

        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        pc_d     = '0;
                        count_d  = '0;
                        done_d   = 1'b0;
                        state_d  = step_mode ? STEP_WAIT : RUN;
                        launch_d = !step_mode;
                    end
                end
                // The first free-run cycle only launches, so mem[0] lands two edges after start.
                RUN:       fetch_en = !launch_q;
                STEP_WAIT: fetch_en = step;
                default:   state_d  = IDLE;
            endcase
        end

        if (fetch_en) begin
            if (fetch_w[31:26] == HALT_OP) begin
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                instr_d = fetch_w;
                valid_d = 1'b1;
                count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                if (pc_q == AW'(DEPTH - 1)) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    pc_d = pc_q + AW'(1);
                end
            end
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = busy_w;
    assign done        = done_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table-driven programs, hand-written
// corner sequences and randomized programs checked against a program-level model.
module tb_instr_sequencer;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam logic [5:0] HALT = 6'b111111;

    localparam logic [31:0] W_LW1  = {6'h23, 5'd0, 5'd1, 16'd1};
    localparam logic [31:0] W_LW2  = {6'h23, 5'd1, 5'd2, 16'd1};
    localparam logic [31:0] W_ADD  = {6'h00, 5'd0, 5'd1, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] W_HALT = {HALT, 26'h0};

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;
    logic          start, step_mode, step, abort;
    logic [31:0]   instr;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          busy, done;
    logic [15:0]   instr_count;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .step_mode(step_mode),
        .step(step), .abort(abort), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .busy(busy), .done(done), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mdl [DEPTH];
    logic [31:0] got [$];
    logic [31:0] exp_q [$];
    int first_n, last_n, bubble_bad, steps_hi;

    typedef struct {
        int halt_at;   // DEPTH means no halt word in the buffer
        bit mode;      // 1 = single-step run
        int exp_cnt;
        int exp_pc;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
        cyc();
        prog_we = 1'b0;
        mdl[a] = d;
    endtask

    // Program-level expectation: words from address 0 up to the first halt, no wrap.
    task automatic model_expect(output int cnt, output int pcx);
        exp_q.delete();
        pcx = DEPTH - 1;
        for (int a = 0; a < DEPTH; a++) begin
            if (mdl[a][31:26] == HALT) begin
                pcx = a;
                break;
            end
            exp_q.push_back(mdl[a]);
        end
        cnt = exp_q.size();
    endtask

    task automatic sample();
        if (instr_valid) begin
            got.push_back(instr);
        end else if (instr != 32'h0) begin
            bubble_bad++;
        end
    endtask

    task automatic run_free();
        int n, guard;
        got.delete(); first_n = -1; last_n = -1; bubble_bad = 0;
        step_mode = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0; prog_we = 1'b0;
        n = 0; guard = 0;
        do begin
            cyc();
            n++; guard++;
            if (instr_valid) begin
                if (first_n < 0) first_n = n;
                last_n = n;
            end
            sample();
        end while (!done && guard < 60);
        if (!done) check("run_free_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_step(input int gap, input bit rnd, input bit we_busy);
        int guard;
        got.delete(); bubble_bad = 0; steps_hi = 0;
        step_mode = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0; step_mode = 1'b0;
        if (we_busy) begin
            check("busy_in_step", 32'(busy), 32'd1);
            prog_we = 1'b1; prog_addr = AW'(2); prog_data = 32'hDEADBEEF;
            cyc();
            prog_we = 1'b0;
            if (instr_valid || instr != 32'h0) bubble_bad++;
        end
        guard = 0;
        do begin
            step = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
            if (step) steps_hi++;
            step = 1'b0;
            sample();
            guard++;
            if (!done && !rnd) begin
                repeat (gap) begin
                    cyc();
                    if (instr_valid || instr != 32'h0) bubble_bad++;
                end
            end
        end while (!done && guard < 200);
        if (!done) check("run_step_timeout", 32'd0, 32'd1);
    endtask

    task automatic compare_run(input string nm, input int cnt, input int pcx);
        check({nm, "_issued"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_word%0d", nm, i), got[i], exp_q[i]);
        check({nm, "_count"}, 32'(instr_count), 32'(cnt));
        check({nm, "_pc"}, 32'(pc), 32'(pcx));
        check({nm, "_done"}, 32'(done), 32'd1);
        check({nm, "_busy"}, 32'(busy), 32'd0);
        check({nm, "_bubble"}, 32'(bubble_bad), 32'd0);
    endtask

    vec_t tbl [6];

    initial begin
        int cnt, pcx, seen, guard;

        tbl[0] = '{3,     0, 3,  3};
        tbl[1] = '{DEPTH, 0, 16, 15};
        tbl[2] = '{0,     0, 0,  0};
        tbl[3] = '{15,    0, 15, 15};
        tbl[4] = '{1,     1, 1,  1};
        tbl[5] = '{DEPTH, 1, 16, 15};

        rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; step_mode = 1'b0; step = 1'b0; abort = 1'b0;
        for (int a = 0; a < DEPTH; a++) mdl[a] = 32'h0;
        repeat (2) cyc();
        check("rst_instr", instr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        rst = 1'b1;
        cyc();

        // 4-word program, free run: latency and back-to-back issue
        load(0, W_LW1); load(1, W_LW2); load(2, W_ADD); load(3, W_HALT);
        run_free();
        model_expect(cnt, pcx);
        compare_run("prog4_free", 3, 3);
        check("prog4_first_edge", 32'(first_n), 32'd2);
        check("prog4_back_to_back", 32'(last_n - first_n + 1), 32'd3);

        // Same program single-stepped; a write attempted while busy must be dropped
        run_step(3, 1'b0, 1'b1);
        model_expect(cnt, pcx);
        compare_run("prog4_step", 3, 3);
        check("prog4_step_pulses", 32'(steps_hi), 32'd4);
        check("prog4_step_third", got.size() > 2 ? got[2] : 32'hX, W_ADD);

        // Table-driven programs
        foreach (tbl[i]) begin
            for (int a = 0; a < DEPTH; a++)
                load(a, (a == tbl[i].halt_at) ? W_HALT
                        : (32'h2000_0000 | 32'(i << 8) | 32'(a)));
            if (tbl[i].mode) run_step(1, 1'b0, 1'b0);
            else             run_free();
            model_expect(cnt, pcx);
            compare_run($sformatf("tbl%0d", i), tbl[i].exp_cnt, tbl[i].exp_pc);
        end

        // abort after 4 issues, then restart from address 0
        for (int a = 0; a < DEPTH; a++)
            load(a, (a < 10) ? (32'h8C00_0000 | 32'(a)) : W_HALT);
        step_mode = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0; seen = 0; guard = 0;
        while (seen < 4 && guard < 20) begin
            cyc();
            if (instr_valid) seen++;
            guard++;
        end
        check("abort_reached4", 32'(seen), 32'd4);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_valid", 32'(instr_valid), 32'd0);
        check("abort_instr", instr, 32'h0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_count", 32'(instr_count), 32'd4);
        check("abort_pc", 32'(pc), 32'd4);
        run_free();
        model_expect(cnt, pcx);
        compare_run("abort_rerun", 10, 10);

        // abort beats start in the same cycle
        abort = 1'b1; start = 1'b1;
        cyc();
        abort = 1'b0; start = 1'b0;
        check("abort_over_start_busy", 32'(busy), 32'd0);
        check("abort_over_start_done", 32'(done), 32'd0);

        // write and start on the same edge: new word is the first one issued
        prog_we = 1'b1; prog_addr = '0; prog_data = 32'h2345_6789;
        mdl[0] = 32'h2345_6789;
        run_free();
        model_expect(cnt, pcx);
        compare_run("we_with_start", 10, 10);

        // asynchronous reset mid-run, between edges
        for (int a = 0; a < DEPTH; a++) load(a, 32'h0100_0000 + 32'(a * 3));
        step_mode = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        #3 rst = 1'b0;
        #1;
        check("arst_instr", instr, 32'h0);
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_pc", 32'(pc), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_count", 32'(instr_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_free();
        model_expect(cnt, pcx);
        compare_run("arst_rerun", 16, 15);

        // randomized programs, free or single-step with random step patterns
        for (int t = 0; t < 10; t++) begin
            int h;
            bit m;
            h = $urandom_range(0, DEPTH + 4);
            m = 1'($urandom_range(0, 1));
            for (int a = 0; a < DEPTH; a++) begin
                logic [31:0] w;
                w = $urandom;
                if (a == h) w[31:26] = HALT;
                load(a, w);
            end
            model_expect(cnt, pcx);
            if (m) run_step(0, 1'b1, 1'b0);
            else   run_free();
            compare_run($sformatf("rnd%0d", t), cnt, pcx);
            if (m) check($sformatf("rnd%0d_steps", t), 32'(steps_hi),
                         32'(cnt + ((cnt < DEPTH) ? 1 : 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
